// File: rtl/syn_pcm_mem_rd_pkg.sv
// Shared types for the PCM buffer read controller: FSM states, read owners,
// the tag that travels alongside each memory read, and error-bit positions.
package syn_pcm_mem_rd_pkg;

  // Address width carried in the tag; the controller's ADDR_W must not exceed it.
  localparam int unsigned TAG_ADDR_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  typedef enum logic {
    OWN_BST = 1'b0,
    OWN_LB  = 1'b1
  } owner_e;

  typedef struct packed {
    logic                  vld;
    owner_e                owner;
    logic [TAG_ADDR_W-1:0] addr;
  } rd_tag_t;

  // err_flag bit positions
  localparam int ERR_VLD_BIT = 0;  // tag valid disagreed with memory valid
  localparam int ERR_OVR_BIT = 1;  // new buffer-ready edge while a burst was busy

endpackage

// File: rtl/syn_pcm_rd_tag_pipe.sv
// Fixed-latency tag delay line: each tag re-appears RD_DELAY cycles after it
// enters, aligned with the memory's read data. Also reports whether any burst
// read is still travelling through the line.
module syn_pcm_rd_tag_pipe
  import syn_pcm_mem_rd_pkg::*;
#(
  parameter int RD_DELAY = 2
) (
  input  logic    clk_ir,
  input  logic    rst_il,
  input  rd_tag_t tag_in,
  output rd_tag_t tag_out,
  output logic    bst_in_flight
);

  rd_tag_t pipe_q [RD_DELAY];

  // Shift tags one stage per cycle.
  // NOTE: this array is cleared on reset because stale valid bits would be
  // mistaken for live reads; plain data storage would not need a reset.
  always_ff @(posedge clk_ir or negedge rst_il) begin
    if (!rst_il) begin
      for (int i = 0; i < RD_DELAY; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= tag_in;
      for (int i = 1; i < RD_DELAY; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign tag_out = pipe_q[RD_DELAY-1];

  // OR-reduce burst-owned valid tags across all stages.
  always_comb begin
    bst_in_flight = 1'b0;
    for (int i = 0; i < RD_DELAY; i++) begin
      if (pipe_q[i].vld && pipe_q[i].owner == OWN_BST) bst_in_flight = 1'b1;
    end
  end

endmodule

// File: rtl/syn_pcm_mem_rd_ctrl.sv
// PCM buffer read controller: sequences a sample burst on each buffer-ready
// edge, fairly interleaves single-word host reads, and steers fixed-latency
// read data back to its requester using a tag pipeline.
module syn_pcm_mem_rd_ctrl
  import syn_pcm_mem_rd_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = TAG_ADDR_W,
  parameter int RD_DELAY    = 2,
  parameter int NUM_SAMPLES = 128
) (
  input  logic              clk_ir,
  input  logic              rst_il,
  input  logic              pcm_data_rdy,
  output logic [ADDR_W-1:0] pcm_addr,
  output logic              pcm_rden,
  input  logic [DATA_W-1:0] pcm_rdata,
  input  logic              pcm_rd_valid,
  input  logic              bst_rdy,
  output logic              bst_valid,
  output logic [DATA_W-1:0] bst_data,
  output logic [ADDR_W-1:0] bst_idx,
  output logic              bst_done,
  input  logic              lb_rd_req,
  input  logic [ADDR_W-1:0] lb_addr,
  output logic              lb_rd_ack,
  output logic              lb_rd_valid,
  output logic [DATA_W-1:0] lb_rdata,
  input  logic              err_clr,
  output logic [1:0]        err_flag
);

  // One extra bit so a burst of 2^ADDR_W samples does not wrap.
  localparam int CNT_W = ADDR_W + 1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               rdy_d;
  logic               start_edge;
  logic               prio_lb_q;
  logic               bst_req, gnt_bst, gnt_lb;
  rd_tag_t            iss_tag_d, iss_tag_q;
  rd_tag_t            ret_tag;
  logic               pipe_bst_in_flight;
  logic               bst_in_flight;
  logic [1:0]         err_set;

  assign start_edge = pcm_data_rdy & ~rdy_d;
  assign bst_req    = (state_q == ST_BURST) && bst_rdy;

  // Grant: a lone requester wins; under contention the previous loser wins.
  always_comb begin
    gnt_bst = bst_req && (!lb_rd_req || !prio_lb_q);
    gnt_lb  = lb_rd_req && (!bst_req || prio_lb_q);
  end

  assign lb_rd_ack = gnt_lb;

  // Tag for the read granted this cycle; address is zero when nothing issues.
  always_comb begin
    iss_tag_d       = '0;
    iss_tag_d.vld   = gnt_bst || gnt_lb;
    iss_tag_d.owner = gnt_lb ? OWN_LB : OWN_BST;
    if (gnt_lb)       iss_tag_d.addr = TAG_ADDR_W'(lb_addr);
    else if (gnt_bst) iss_tag_d.addr = TAG_ADDR_W'(cnt_q[ADDR_W-1:0]);
  end

  assign bst_in_flight = pipe_bst_in_flight || bst_valid ||
                         (iss_tag_q.vld && iss_tag_q.owner == OWN_BST);

  // Next-state, burst counter and done pulse.
  // NOTE: every output of this block gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bst_done = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_edge) begin
          state_d = ST_BURST;
          cnt_d   = '0;
        end
      end
      ST_BURST: begin
        if (gnt_bst) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(NUM_SAMPLES - 1)) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!bst_in_flight) begin
          bst_done = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counter, edge detector and fairness pointer.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_ir or negedge rst_il) begin
    if (!rst_il) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      rdy_d     <= 1'b0;
      prio_lb_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdy_d   <= pcm_data_rdy;
      if (bst_req && lb_rd_req) prio_lb_q <= gnt_bst;
    end
  end

  // Registered issue stage: drives the memory strobe/address and feeds the tags.
  always_ff @(posedge clk_ir or negedge rst_il) begin
    if (!rst_il) iss_tag_q <= '0;
    else         iss_tag_q <= iss_tag_d;
  end

  assign pcm_rden = iss_tag_q.vld;
  assign pcm_addr = ADDR_W'(iss_tag_q.addr);

  syn_pcm_rd_tag_pipe #(
    .RD_DELAY (RD_DELAY)
  ) u_tag_pipe (
    .clk_ir        (clk_ir),
    .rst_il        (rst_il),
    .tag_in        (iss_tag_q),
    .tag_out       (ret_tag),
    .bst_in_flight (pipe_bst_in_flight)
  );

  // Registered return stage: steer read data by the emerging tag's owner.
  always_ff @(posedge clk_ir or negedge rst_il) begin
    if (!rst_il) begin
      bst_valid   <= 1'b0;
      bst_data    <= '0;
      bst_idx     <= '0;
      lb_rd_valid <= 1'b0;
      lb_rdata    <= '0;
    end else begin
      bst_valid   <= ret_tag.vld && (ret_tag.owner == OWN_BST);
      bst_data    <= (ret_tag.vld && ret_tag.owner == OWN_BST) ? pcm_rdata : '0;
      bst_idx     <= (ret_tag.vld && ret_tag.owner == OWN_BST) ? ADDR_W'(ret_tag.addr) : '0;
      lb_rd_valid <= ret_tag.vld && (ret_tag.owner == OWN_LB);
      lb_rdata    <= (ret_tag.vld && ret_tag.owner == OWN_LB) ? pcm_rdata : '0;
    end
  end

  always_comb begin
    err_set              = '0;
    err_set[ERR_VLD_BIT] = ret_tag.vld != pcm_rd_valid;
    err_set[ERR_OVR_BIT] = start_edge && (state_q != ST_IDLE);
  end

  // Sticky error flags; a new error wins over a simultaneous clear.
  always_ff @(posedge clk_ir or negedge rst_il) begin
    if (!rst_il) err_flag <= '0;
    else         err_flag <= err_set | (err_clr ? 2'b00 : err_flag);
  end

endmodule

// File: tb/tb_syn_pcm_mem_rd_ctrl.sv
// Directed bench for syn_pcm_mem_rd_ctrl with NUM_SAMPLES=4, RD_DELAY=2 and a
// memory returning 0xA000+addr. Output events are logged with their cycle
// number and compared against hand-computed cycle/value tables.
module tb_syn_pcm_mem_rd_ctrl;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 8;
  localparam int RD_DLY = 2;
  localparam int NSAMP  = 4;

  logic              clk_ir = 1'b0;
  logic              rst_il = 1'b0;
  logic              pcm_data_rdy = 1'b0;
  logic [ADDR_W-1:0] pcm_addr;
  logic              pcm_rden;
  logic [DATA_W-1:0] pcm_rdata;
  logic              pcm_rd_valid;
  logic              bst_rdy = 1'b0;
  logic              bst_valid;
  logic [DATA_W-1:0] bst_data;
  logic [ADDR_W-1:0] bst_idx;
  logic              bst_done;
  logic              lb_rd_req = 1'b0;
  logic [ADDR_W-1:0] lb_addr = '0;
  logic              lb_rd_ack;
  logic              lb_rd_valid;
  logic [DATA_W-1:0] lb_rdata;
  logic              err_clr = 1'b0;
  logic [1:0]        err_flag;

  syn_pcm_mem_rd_ctrl #(
    .DATA_W (DATA_W), .ADDR_W (ADDR_W), .RD_DELAY (RD_DLY), .NUM_SAMPLES (NSAMP)
  ) dut (
    .clk_ir (clk_ir), .rst_il (rst_il), .pcm_data_rdy (pcm_data_rdy),
    .pcm_addr (pcm_addr), .pcm_rden (pcm_rden), .pcm_rdata (pcm_rdata),
    .pcm_rd_valid (pcm_rd_valid), .bst_rdy (bst_rdy), .bst_valid (bst_valid),
    .bst_data (bst_data), .bst_idx (bst_idx), .bst_done (bst_done),
    .lb_rd_req (lb_rd_req), .lb_addr (lb_addr), .lb_rd_ack (lb_rd_ack),
    .lb_rd_valid (lb_rd_valid), .lb_rdata (lb_rdata), .err_clr (err_clr),
    .err_flag (err_flag)
  );

  always #5 clk_ir = ~clk_ir;

  int cyc = 0;
  always @(posedge clk_ir) cyc <= cyc + 1;

  // Memory model: fixed RD_DLY latency, data = 0xA000 + addr; can drop the
  // valid strobe for one chosen address.
  logic              m_v [RD_DLY] = '{default: 1'b0};
  logic [ADDR_W-1:0] m_a [RD_DLY] = '{default: '0};
  logic              supp_en   = 1'b0;
  logic [ADDR_W-1:0] supp_addr = '0;

  always @(posedge clk_ir) begin
    m_v[0] <= pcm_rden;
    m_a[0] <= pcm_addr;
    for (int i = 1; i < RD_DLY; i++) begin
      m_v[i] <= m_v[i-1];
      m_a[i] <= m_a[i-1];
    end
  end

  assign pcm_rdata    = m_v[RD_DLY-1] ? (32'hA000 + 32'(m_a[RD_DLY-1])) : '0;
  assign pcm_rd_valid = m_v[RD_DLY-1] && !(supp_en && m_a[RD_DLY-1] == supp_addr);

  typedef struct {
    int          cyc;
    int          idx;
    logic [31:0] data;
  } ev_t;

  ev_t bst_q[$];
  ev_t lb_q[$];
  ev_t done_q[$];
  ev_t ack_q[$];
  ev_t rden_q[$];

  // Event logger, sampled mid-cycle.
  always @(negedge clk_ir) begin
    if (bst_valid)   bst_q.push_back('{cyc, int'(bst_idx), bst_data});
    if (lb_rd_valid) lb_q.push_back('{cyc, 0, lb_rdata});
    if (bst_done)    done_q.push_back('{cyc, 0, 32'h0});
    if (lb_rd_ack)   ack_q.push_back('{cyc, 0, 32'h0});
    if (pcm_rden)    rden_q.push_back('{cyc, int'(pcm_addr), 32'h0});
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_ir);
      #1;
    end
  endtask

  task automatic clear_logs();
    bst_q.delete(); lb_q.delete(); done_q.delete(); ack_q.delete(); rden_q.delete();
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_bst_valid"}, 64'(bst_valid), 0);
    check({tag, "_bst_data"},  64'(bst_data), 0);
    check({tag, "_bst_idx"},   64'(bst_idx), 0);
    check({tag, "_bst_done"},  64'(bst_done), 0);
    check({tag, "_rden"},      64'(pcm_rden), 0);
    check({tag, "_addr"},      64'(pcm_addr), 0);
    check({tag, "_lb_valid"},  64'(lb_rd_valid), 0);
    check({tag, "_lb_rdata"},  64'(lb_rdata), 0);
    check({tag, "_err"},       64'(err_flag), 0);
  endtask

  // Compare logged burst words against expected cycles, indices 0..N-1.
  task automatic check_burst(input string tag, input int exp_cyc [NSAMP], input int exp_done);
    check({tag, "_nbst"}, 64'(bst_q.size()), NSAMP);
    for (int i = 0; i < bst_q.size() && i < NSAMP; i++) begin
      check({tag, "_bst_cyc"},  64'(bst_q[i].cyc), 64'(exp_cyc[i]));
      check({tag, "_bst_idx"},  64'(bst_q[i].idx), 64'(i));
      check({tag, "_bst_data"}, 64'(bst_q[i].data), 64'(32'hA000 + i));
    end
    check({tag, "_ndone"}, 64'(done_q.size()), 1);
    if (done_q.size() > 0) check({tag, "_done_cyc"}, 64'(done_q[0].cyc), 64'(exp_done));
  endtask

  int k;
  int ecyc [NSAMP];
  int exp_rden_addr [7] = '{0, 'h10, 1, 'h10, 2, 'h10, 3};

  initial begin
    // Reset state
    tick(3);
    check_zero_outputs("rst");
    rst_il = 1'b1;
    tick(2);

    // 1: plain burst, one word per cycle, done one cycle after the last word
    clear_logs();
    k = cyc; pcm_data_rdy = 1'b1; bst_rdy = 1'b1;
    tick(14);
    ecyc = '{k+5, k+6, k+7, k+8};
    check_burst("t1", ecyc, k+9);
    check("t1_err", 64'(err_flag), 0);
    pcm_data_rdy = 1'b0;
    tick(2);

    // 2: idle host read of 0x3C
    clear_logs();
    k = cyc; lb_rd_req = 1'b1; lb_addr = 8'h3C;
    tick(1);
    lb_rd_req = 1'b0;
    tick(6);
    check("t2_nack", 64'(ack_q.size()), 1);
    if (ack_q.size() > 0) check("t2_ack_cyc", 64'(ack_q[0].cyc), 64'(k));
    check("t2_nrden", 64'(rden_q.size()), 1);
    if (rden_q.size() > 0) begin
      check("t2_rden_cyc",  64'(rden_q[0].cyc), 64'(k+1));
      check("t2_rden_addr", 64'(rden_q[0].idx), 64'h3C);
    end
    check("t2_nlb", 64'(lb_q.size()), 1);
    if (lb_q.size() > 0) begin
      check("t2_lb_cyc",  64'(lb_q[0].cyc), 64'(k+4));
      check("t2_lb_data", 64'(lb_q[0].data), 64'hA03C);
    end

    // 3: host holds its request through a burst; grants alternate BST/LB
    clear_logs();
    k = cyc; pcm_data_rdy = 1'b1;
    tick(1);
    lb_rd_req = 1'b1; lb_addr = 8'h10;
    tick(7);
    lb_rd_req = 1'b0;
    tick(8);
    check("t3_nrden", 64'(rden_q.size()), 7);
    for (int i = 0; i < rden_q.size() && i < 7; i++) begin
      check("t3_rden_cyc",  64'(rden_q[i].cyc), 64'(k+2+i));
      check("t3_rden_addr", 64'(rden_q[i].idx), 64'(exp_rden_addr[i]));
    end
    check("t3_nack", 64'(ack_q.size()), 3);
    for (int i = 0; i < ack_q.size() && i < 3; i++)
      check("t3_ack_cyc", 64'(ack_q[i].cyc), 64'(k+2+2*i));
    ecyc = '{k+5, k+7, k+9, k+11};
    check_burst("t3", ecyc, k+12);
    check("t3_nlb", 64'(lb_q.size()), 3);
    for (int i = 0; i < lb_q.size() && i < 3; i++) begin
      check("t3_lb_cyc",  64'(lb_q[i].cyc), 64'(k+6+2*i));
      check("t3_lb_data", 64'(lb_q[i].data), 64'hA010);
    end
    check("t3_err", 64'(err_flag), 0);
    pcm_data_rdy = 1'b0;
    tick(2);

    // 4: second ready edge mid-burst -> overrun flag, burst unaffected
    clear_logs();
    k = cyc; pcm_data_rdy = 1'b1;
    tick(2);
    pcm_data_rdy = 1'b0;
    tick(1);
    pcm_data_rdy = 1'b1;
    tick(12);
    ecyc = '{k+5, k+6, k+7, k+8};
    check_burst("t4", ecyc, k+9);
    check("t4_err", 64'(err_flag), 64'b10);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    check("t4_err_clr", 64'(err_flag), 0);
    pcm_data_rdy = 1'b0;
    tick(2);

    // 5: dropped memory valid on idx 2 plus loader backpressure
    clear_logs();
    supp_en = 1'b1; supp_addr = 8'd2;
    k = cyc; pcm_data_rdy = 1'b1;
    tick(2);
    bst_rdy = 1'b0;
    tick(2);
    bst_rdy = 1'b1;
    tick(12);
    ecyc = '{k+5, k+8, k+9, k+10};
    check_burst("t5", ecyc, k+11);
    check("t5_err", 64'(err_flag), 64'b01);
    supp_en = 1'b0;
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    check("t5_err_clr", 64'(err_flag), 0);
    pcm_data_rdy = 1'b0;
    tick(2);

    // 6: reset in the middle of a burst, ready held high through release
    clear_logs();
    k = cyc; pcm_data_rdy = 1'b1;
    tick(6);
    check("t6_pre_valid", 64'(bst_valid), 1);
    rst_il = 1'b0;
    #1;
    check_zero_outputs("t6_rst");
    tick(3);
    check("t6_rst_nbst", 64'(bst_q.size()), 1);
    check("t6_rst_ndone", 64'(done_q.size()), 0);
    clear_logs();
    rst_il = 1'b1;
    k = cyc;
    tick(14);
    ecyc = '{k+5, k+6, k+7, k+8};
    check_burst("t6", ecyc, k+9);
    check("t6_err", 64'(err_flag), 0);
    pcm_data_rdy = 1'b0;
    tick(2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/syn_pcm_mem_rd_ctrl.md
# syn_pcm_mem_rd_ctrl

PCM memory read controller and arbiter sitting between Acortex's PCM buffer read port and its two consumers: the Fgyrus sample loader (burst) and the local-bus host (single-word debug reads). On each new `pcm_data_rdy` it sequences a full sample burst out of the buffer. It interleaves host reads fairly with that burst, and steers the fixed-latency read data back to the correct requester using an internal tag pipeline.

## Interface
- `DATA_W`, 32, PCM word width
- `ADDR_W`, 8, PCM buffer address width
- `RD_DELAY`, 2, memory latency from `pcm_rden` to `pcm_rdata` (≥2)
- `NUM_SAMPLES`, 128, words per burst (1..2^ADDR_W)

- `clk_ir` in 1: single clock; everything is synchronous to its rising edge
- `rst_il` in 1: reset, asynchronous and active-low
- `pcm_data_rdy` in 1: buffer filled (level; a rising edge starts a burst)
- `pcm_addr` out ADDR_W: read address
- `pcm_rden` out 1: read strobe
- `pcm_rdata` in DATA_W: read data
- `pcm_rd_valid` in 1: memory's own data-valid, checked only
- `bst_rdy` in 1: loader can accept issue
- `bst_valid` out 1: burst word valid
- `bst_data` out DATA_W: burst word
- `bst_idx` out ADDR_W: sample index of `bst_data`
- `bst_done` out 1: one-cycle pulse after the last burst word
- `lb_rd_req` in 1: host read request; held until acked
- `lb_addr` in ADDR_W: host read address
- `lb_rd_ack` out 1: combinational grant
- `lb_rd_valid` out 1: host data valid
- `lb_rdata` out DATA_W: host data
- `err_clr` in 1: clears `err_flag`
- `err_flag` out 2: sticky error bits; [0] valid mismatch, [1] overrun

## Operation
- Start edge = `pcm_data_rdy & ~rdy_d`. `rdy_d` resets to 0, so a level already high at reset release starts a burst.
- FSM states:
  - IDLE: a start edge moves the FSM to BURST and clears the burst counter.
  - BURST: issues addresses 0..NUM_SAMPLES-1. The burst requests only while `bst_rdy`=1. After the last issue the FSM moves to DRAIN.
  - DRAIN: waits until no burst tag is in flight, pulses `bst_done`, then moves to IDLE.
- A start edge in BURST or DRAIN sets `err_flag[1]`. The edge is dropped and the burst in progress continues.
- Arbitration runs each cycle between the burst request and `lb_rd_req`:
  - If only one requester is active, it wins.
  - If both are active, the loser of the previous contended cycle wins. After reset, burst has priority.
  - Host reads are served in every state.
- A grant in cycle t produces a registered `pcm_rden`=1 and `pcm_addr` in cycle t+1. It also pushes the tag {vld, owner, addr} into the tag pipeline.
- The tag emerges aligned with `pcm_rdata`. Owner BST drives `bst_valid`/`bst_data`/`bst_idx`; owner LB drives `lb_rd_valid`/`lb_rdata`.
- Whenever emerging tag vld ≠ `pcm_rd_valid`, `err_flag[0]` is set. Data is still steered according to the tag.
- `err_clr` clears both `err_flag` bits. If `err_clr` coincides with a new error, the set wins.
- Backpressure: after `bst_rdy` deasserts, the loader must still absorb up to RD_DELAY+1 in-flight words.
- Reset at any time:
  - FSM returns to IDLE; counter, arbitration pointer and tag pipeline are cleared.
  - All outputs are 0.
  - In-flight data is discarded and `bst_done` does not fire.

## Timing
- Host read latency: ack in cycle t, `lb_rd_valid` in cycle t+2+RD_DELAY (registered output stage).
- Burst read latency: grant to `bst_valid` is also 2+RD_DELAY cycles.
- Throughput with `bst_rdy`=1 and no host traffic: one word per cycle. A burst occupies NUM_SAMPLES+RD_DELAY+3 cycles from the start edge to `bst_done`.
- `bst_done` is asserted in the cycle after the final `bst_valid`.
- The host must drop `lb_rd_req` in the cycle after `lb_rd_ack`, or it issues a new read.
- The burst counter is ADDR_W+1 bits wide so that NUM_SAMPLES=2^ADDR_W does not wrap. `pcm_addr` takes the low ADDR_W bits.

## Structure
- Package `syn_pcm_mem_rd_pkg` contains:
  - the FSM state enum (IDLE/BURST/DRAIN)
  - the owner enum (BST/LB)
  - the tag struct `{vld, owner, addr[ADDR_W]}`
  - the `err_flag` bit index constants
- Sub-module `syn_pcm_rd_tag_pipe`: RD_DELAY-deep shift register of tags with asynchronous active-low clear. It also provides a "burst tag in flight" OR-reduction used by DRAIN.

## Test plan
- NUM_SAMPLES=4, RD_DELAY=2, memory word = 0xA000+addr; `pcm_data_rdy` rises with `bst_rdy`=1 → `bst_data` 0xA000..0xA003 on 4 consecutive cycles with `bst_idx` 0..3, then `bst_done` one cycle later.
- Idle state, `lb_rd_req` with `lb_addr`=0x3C at cycle t → `lb_rd_ack`@t, `pcm_rden`/`pcm_addr`=0x3C @t+1, `lb_rd_valid` with `lb_rdata`=0xA03C @t+4.
- Host holds `lb_rd_req` throughout a burst → grants alternate BST/LB/BST/…, all burst words correct, and `bst_done` is delayed accordingly.
- Second `pcm_data_rdy` edge mid-burst → `err_flag`=2'b10, first burst completes unchanged; `err_clr` → `err_flag`=0.
- Memory model suppresses one `pcm_rd_valid` → `err_flag[0]` set, data still delivered; `bst_rdy` toggled mid-burst → no lost or duplicated `bst_idx`.
- Reset asserted in BURST → all outputs 0 immediately; after release with `pcm_data_rdy` held high, a new burst starts from index 0.
